// File: rtl/pali_pkg.sv
// Shared defaults and helpers for the palindrome detector.
// Every statistics counter goes through sat_inc so that none of them can wrap.
package pali_pkg;

   localparam int DEFAULT_WIDTH = 3;
   localparam int DEFAULT_CNT_W = 8;

   // Returns value+1, or value unchanged once it has reached 2^width-1.
   // The value is carried as 32 bits so one function serves any counter width.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_val;
      max_val = 32'hFFFF_FFFF >> (32 - width);
      return (value == max_val) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/pali_mirror_cmp.sv
// Combinational mirror comparator: y is high when the word reads the same in both directions.
// When WIDTH is odd, the middle bit has no partner and is never compared.
module pali_mirror_cmp #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] i,
   output logic             y
);

   // Equality is used so that X or Z on i propagates to y instead of reading as a match.
   always_comb begin
      y = 1'b1;
      for (int k = 0; k < WIDTH / 2; k++) begin
         y = y & (i[k] == i[WIDTH-1-k]);
      end
   end

endmodule

// File: rtl/pali_detect_ter.sv
// Palindrome detector with registered statistics: accepted-word and palindrome counts,
// current palindrome run length, and the most recent palindromic word.
module pali_detect_ter
   import pali_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i,
   input  logic             in_valid,
   input  logic             clr,
   output logic             y,
   output logic             y_q,
   output logic             y_q_valid,
   output logic [CNT_W-1:0] pal_count,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] run_len,
   output logic [WIDTH-1:0] last_pal
);

   pali_mirror_cmp #(
      .WIDTH(WIDTH)
   ) u_cmp (
      .i(i),
      .y(y)
   );

   // Clear wins over a valid word; counters saturate independently of one another,
   // so a saturated word_count still lets pal_count and run_len advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q        <= 1'b0;
         y_q_valid  <= 1'b0;
         pal_count  <= '0;
         word_count <= '0;
         run_len    <= '0;
         last_pal   <= '0;
      end else if (clr) begin
         y_q        <= 1'b0;
         y_q_valid  <= 1'b0;
         pal_count  <= '0;
         word_count <= '0;
         run_len    <= '0;
         last_pal   <= '0;
      end else if (in_valid) begin
         y_q        <= y;
         y_q_valid  <= 1'b1;
         word_count <= CNT_W'(sat_inc(32'(word_count), CNT_W));
         if (y) begin
            pal_count <= CNT_W'(sat_inc(32'(pal_count), CNT_W));
            run_len   <= CNT_W'(sat_inc(32'(run_len), CNT_W));
            last_pal  <= i;
         end else begin
            run_len <= '0;
         end
      end else begin
         y_q_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pali_detect_ter.sv
// Directed bench for pali_detect_ter: default 3-bit instance, a CNT_W=2 instance
// for saturation, and a 4-bit instance for even-width checks.
module tb_pali_detect_ter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic clr;

   logic [2:0] i3;
   logic       v3;
   logic       y3, yq3, yqv3;
   logic [7:0] pc3, wc3, rl3;
   logic [2:0] lp3;

   logic [2:0] is;
   logic       vs;
   logic       ys, yqs, yqvs;
   logic [1:0] pcs, wcs, rls;
   logic [2:0] lps;

   logic [3:0] i4;
   logic       v4;
   logic       y4, yq4, yqv4;
   logic [7:0] pc4, wc4, rl4;
   logic [3:0] lp4;

   int checks = 0;
   int failures = 0;

   pali_detect_ter #(.WIDTH(3), .CNT_W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .i(i3), .in_valid(v3), .clr(clr),
      .y(y3), .y_q(yq3), .y_q_valid(yqv3),
      .pal_count(pc3), .word_count(wc3), .run_len(rl3), .last_pal(lp3)
   );

   pali_detect_ter #(.WIDTH(3), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .i(is), .in_valid(vs), .clr(clr),
      .y(ys), .y_q(yqs), .y_q_valid(yqvs),
      .pal_count(pcs), .word_count(wcs), .run_len(rls), .last_pal(lps)
   );

   pali_detect_ter #(.WIDTH(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .i(i4), .in_valid(v4), .clr(clr),
      .y(y4), .y_q(yq4), .y_q_valid(yqv4),
      .pal_count(pc4), .word_count(wc4), .run_len(rl4), .last_pal(lp4)
   );

   // Reset asserted from time zero: every register of every instance reads zero.
   task automatic test_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      i3 = 3'b000; v3 = 1'b0;
      is = 3'b000; vs = 1'b0;
      i4 = 4'b0000; v4 = 1'b0;
      #3;
      checks++;
      if ({yq3, yqv3, pc3, wc3, rl3, lp3} !== 30'd0) begin
         failures++;
         $display("[TB] FAIL reset_main: got %h expected 0", {yq3, yqv3, pc3, wc3, rl3, lp3});
      end
      checks++;
      if ({yqs, yqvs, pcs, wcs, rls, lps} !== 11'd0) begin
         failures++;
         $display("[TB] FAIL reset_sat: got %h expected 0", {yqs, yqvs, pcs, wcs, rls, lps});
      end
      checks++;
      if ({yq4, yqv4, pc4, wc4, rl4, lp4} !== 30'd0) begin
         failures++;
         $display("[TB] FAIL reset_w4: got %h expected 0", {yq4, yqv4, pc4, wc4, rl4, lp4});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      logic [7:0] exp_y;
      exp_y = 8'b1010_0101;
      v3 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         i3 = 3'(k);
         #5;
         checks++;
         if (y3 !== exp_y[k]) begin
            failures++;
            $display("[TB] FAIL sweep_y i=%b: got %b expected %b", i3, y3, exp_y[k]);
         end
      end
   endtask

   task automatic test_sequence();
      logic [2:0] seq    [5] = '{3'b101, 3'b111, 3'b010, 3'b011, 3'b000};
      logic       exp_yq [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp_pc [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd4};
      logic [7:0] exp_rl [5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
      logic [2:0] exp_lp [5] = '{3'b101, 3'b111, 3'b010, 3'b010, 3'b000};
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int n = 0; n < 5; n++) begin
         i3 = seq[n];
         v3 = 1'b1;
         @(negedge clk);
         checks++;
         if ({yqv3, yq3} !== {1'b1, exp_yq[n]}) begin
            failures++;
            $display("[TB] FAIL seq_yq step %0d: got valid=%b y_q=%b expected valid=1 y_q=%b", n, yqv3, yq3, exp_yq[n]);
         end
         checks++;
         if ({pc3, wc3, rl3, lp3} !== {exp_pc[n], 8'(n + 1), exp_rl[n], exp_lp[n]}) begin
            failures++;
            $display("[TB] FAIL seq_stats step %0d: got pc=%0d wc=%0d rl=%0d lp=%b expected pc=%0d wc=%0d rl=%0d lp=%b",
                     n, pc3, wc3, rl3, lp3, exp_pc[n], n + 1, exp_rl[n], exp_lp[n]);
         end
      end
      v3 = 1'b0;
      @(negedge clk);
      checks++;
      if (yqv3 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL seq_valid_drop: got %b expected 0", yqv3);
      end
      checks++;
      if ({pc3, wc3, rl3, lp3} !== {8'd4, 8'd5, 8'd1, 3'b000}) begin
         failures++;
         $display("[TB] FAIL seq_hold: got pc=%0d wc=%0d rl=%0d lp=%b expected pc=4 wc=5 rl=1 lp=000", pc3, wc3, rl3, lp3);
      end
   endtask

   task automatic test_clr();
      @(negedge clk);
      i3  = 3'b101;
      v3  = 1'b1;
      clr = 1'b1;
      #1;
      checks++;
      if (y3 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL clr_y_before: got %b expected 1", y3);
      end
      @(negedge clk);
      checks++;
      if ({yq3, yqv3, pc3, wc3, rl3, lp3} !== 30'd0) begin
         failures++;
         $display("[TB] FAIL clr_stats: got %h expected 0", {yq3, yqv3, pc3, wc3, rl3, lp3});
      end
      checks++;
      if (y3 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL clr_y_after: got %b expected 1", y3);
      end
      clr = 1'b0;
      v3  = 1'b0;
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 6; n++) begin
         is = 3'b111;
         vs = 1'b1;
         @(negedge clk);
      end
      vs = 1'b0;
      checks++;
      if ({pcs, wcs, rls} !== {2'd3, 2'd3, 2'd3}) begin
         failures++;
         $display("[TB] FAIL sat_all: got pc=%0d wc=%0d rl=%0d expected pc=3 wc=3 rl=3", pcs, wcs, rls);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      // Saturate word_count with non-palindromes, then confirm palindromes still count.
      for (int n = 0; n < 3; n++) begin
         is = 3'b011;
         vs = 1'b1;
         @(negedge clk);
      end
      for (int n = 0; n < 2; n++) begin
         is = 3'b101;
         @(negedge clk);
      end
      vs = 1'b0;
      checks++;
      if ({pcs, wcs, rls, lps} !== {2'd2, 2'd3, 2'd2, 3'b101}) begin
         failures++;
         $display("[TB] FAIL sat_word_only: got pc=%0d wc=%0d rl=%0d lp=%b expected pc=2 wc=3 rl=2 lp=101", pcs, wcs, rls, lps);
      end
   endtask

   task automatic test_reset_midrun();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      v3 = 1'b1;
      i3 = 3'b101;
      @(negedge clk);
      i3 = 3'b111;
      @(negedge clk);
      i3 = 3'b010;
      @(negedge clk);
      v3 = 1'b0;
      checks++;
      if ({pc3, wc3, rl3} !== {8'd3, 8'd3, 8'd3}) begin
         failures++;
         $display("[TB] FAIL mid_pre: got pc=%0d wc=%0d rl=%0d expected 3 3 3", pc3, wc3, rl3);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({yq3, yqv3, pc3, wc3, rl3, lp3} !== 30'd0) begin
         failures++;
         $display("[TB] FAIL mid_async: got %h expected 0", {yq3, yqv3, pc3, wc3, rl3, lp3});
      end
      i3 = 3'b011;
      #1;
      checks++;
      if (y3 !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_y_011: got %b expected 0", y3);
      end
      i3 = 3'b101;
      v3 = 1'b1;
      #1;
      checks++;
      if (y3 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mid_y_101: got %b expected 1", y3);
      end
      @(negedge clk);
      checks++;
      if (wc3 !== 8'd0) begin
         failures++;
         $display("[TB] FAIL mid_no_accept: got wc=%0d expected 0", wc3);
      end
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      v3 = 1'b0;
      checks++;
      if ({pc3, wc3, rl3, lp3} !== {8'd1, 8'd1, 8'd1, 3'b101}) begin
         failures++;
         $display("[TB] FAIL mid_restart: got pc=%0d wc=%0d rl=%0d lp=%b expected 1 1 1 101", pc3, wc3, rl3, lp3);
      end
   endtask

   task automatic test_width4();
      logic [3:0] vec [3] = '{4'b1001, 4'b0110, 4'b1011};
      logic       exp [3] = '{1'b1, 1'b1, 1'b0};
      for (int n = 0; n < 3; n++) begin
         i4 = vec[n];
         #1;
         checks++;
         if (y4 !== exp[n]) begin
            failures++;
            $display("[TB] FAIL w4_y i=%b: got %b expected %b", i4, y4, exp[n]);
         end
      end
      @(negedge clk);
      i4 = 4'b0110;
      v4 = 1'b1;
      @(negedge clk);
      v4 = 1'b0;
      checks++;
      if ({yqv4, yq4, lp4, rl4} !== {1'b1, 1'b1, 4'b0110, 8'd1}) begin
         failures++;
         $display("[TB] FAIL w4_accept: got valid=%b y_q=%b lp=%b rl=%0d expected 1 1 0110 1", yqv4, yq4, lp4, rl4);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_sequence();
      test_clr();
      test_saturation();
      test_reset_midrun();
      test_width4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always ends even if a wait misbehaves.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete, got no finish expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
